seg_scan_ctrl: RTL and testbench



---
 rtl/seg_pkg.sv | 17 +
 rtl/scan_tick_gen.sv | 23 ++
 rtl/seg_scan_ctrl.sv | 151 +++++++++++++++
 tb/tb_seg_scan_ctrl.sv | 357 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/seg_pkg.sv
// Shared types and constants for the 7-segment scan controller.
package seg_pkg;

  typedef enum logic {
    PH_BLANK = 1'b0,
    PH_ON    = 1'b1
  } phase_e;

  localparam logic [7:0] SEG_OFF_AL = 8'hFF;
  localparam logic [7:0] SEG_OFF_AH = 8'h00;

  // Inactive segment pattern for the selected drive polarity.
  function automatic logic [7:0] seg_off(input bit active_low);
    return active_low ? SEG_OFF_AL : SEG_OFF_AH;
  endfunction

endpackage

// File: rtl/scan_tick_gen.sv
// Free-running prescaler: one-cycle tick every TICK_DIV clocks.
module scan_tick_gen #(
  parameter int TICK_DIV = 1024
) (
  input  logic clk,
  input  logic rst,
  output logic tick_o
);

  localparam int CW = $clog2(TICK_DIV);

  logic [CW-1:0] cnt_q;

  assign tick_o = (cnt_q == CW'(TICK_DIV - 1));

  // Count 0..TICK_DIV-1 and wrap on the tick cycle.
  always_ff @(posedge clk) begin
    if (rst)         cnt_q <= '0;
    else if (tick_o) cnt_q <= '0;
    else             cnt_q <= cnt_q + 1'b1;
  end

endmodule

// File: rtl/seg_scan_ctrl.sv
// Time-multiplexed common-anode 7-segment driver with PWM brightness,
// inter-digit blanking and frame-aligned double-buffered digit data.
//
// phase    | meaning
// ---------+------------------------------------------------------
// PH_BLANK | BLANK_TICKS ticks, all anodes off (anti-ghosting)
// PH_ON    | 2^BRIGHT_W ticks, digit lit while tick count < brightness
module seg_scan_ctrl
  import seg_pkg::*;
#(
  parameter int NUM_DIGITS  = 4,
  parameter int TICK_DIV    = 1024,
  parameter int BRIGHT_W    = 4,
  parameter int BLANK_TICKS = 2,
  parameter int ACTIVE_LOW  = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [8*NUM_DIGITS-1:0] seg_in,
  input  logic                    load,
  input  logic [NUM_DIGITS-1:0]   digit_en,
  input  logic [BRIGHT_W-1:0]     brightness,
  output logic [7:0]              disp,
  output logic [NUM_DIGITS-1:0]   anode,
  output logic                    frame_tick
);

  localparam int ON_TICKS = 2 ** BRIGHT_W;
  localparam int TMAX     = (ON_TICKS > BLANK_TICKS) ? ON_TICKS : BLANK_TICKS;
  localparam int TW       = $clog2(TMAX);
  localparam int IW       = $clog2(NUM_DIGITS);

  localparam logic [7:0]              SEG_OFF = seg_off(ACTIVE_LOW != 0);
  localparam logic [NUM_DIGITS-1:0]   AN_OFF  = (ACTIVE_LOW != 0) ? {NUM_DIGITS{1'b1}}
                                                                  : {NUM_DIGITS{1'b0}};
  localparam logic [8*NUM_DIGITS-1:0] BUF_OFF = {NUM_DIGITS{SEG_OFF}};

  logic                    tick;
  logic [IW-1:0]           idx_q, idx_d;
  phase_e                  phase_q, phase_d;
  logic [TW-1:0]           tcnt_q, tcnt_d;
  logic [BRIGHT_W-1:0]     bright_q, bright_d;
  logic [8*NUM_DIGITS-1:0] stage_q, stage_d;
  logic [8*NUM_DIGITS-1:0] active_q, active_d;
  logic                    pending_q, pending_d;
  logic [7:0]              disp_q, disp_d;
  logic [NUM_DIGITS-1:0]   anode_q, anode_d;
  logic                    ft_q;
  logic                    boundary;
  logic                    lit;
  logic [NUM_DIGITS-1:0]   onehot;

  scan_tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
    .clk    (clk),
    .rst    (rst),
    .tick_o (tick)
  );

  assign boundary = tick && (phase_q == PH_ON) && (tcnt_q == TW'(ON_TICKS - 1)) &&
                    (idx_q == IW'(NUM_DIGITS - 1));

  // Slot sequencing on ticks plus staging/active buffer handoff.
  always_comb begin
    idx_d     = idx_q;
    phase_d   = phase_q;
    tcnt_d    = tcnt_q;
    bright_d  = bright_q;
    stage_d   = stage_q;
    active_d  = active_q;
    pending_d = pending_q;

    if (tick) begin
      case (phase_q)
        PH_BLANK: begin
          if (tcnt_q == TW'(BLANK_TICKS - 1)) begin
            phase_d  = PH_ON;
            tcnt_d   = '0;
            bright_d = brightness;
          end else begin
            tcnt_d = tcnt_q + 1'b1;
          end
        end
        PH_ON: begin
          if (tcnt_q == TW'(ON_TICKS - 1)) begin
            phase_d = PH_BLANK;
            tcnt_d  = '0;
            idx_d   = (idx_q == IW'(NUM_DIGITS - 1)) ? '0 : idx_q + 1'b1;
          end else begin
            tcnt_d = tcnt_q + 1'b1;
          end
        end
        default: phase_d = PH_BLANK;
      endcase
    end

    // Transfer uses the old staging value; a coincident load re-arms pending.
    if (boundary && pending_q) begin
      active_d  = stage_q;
      pending_d = 1'b0;
    end
    if (load) begin
      stage_d   = seg_in;
      pending_d = 1'b1;
    end
  end

  assign onehot = {{(NUM_DIGITS-1){1'b0}}, 1'b1} << idx_q;
  assign lit    = (phase_q == PH_ON) && digit_en[idx_q] && (tcnt_q < TW'(bright_q));

  // Pin drive derived from the current slot state, registered below.
  always_comb begin
    disp_d  = SEG_OFF;
    anode_d = AN_OFF;
    if (lit) begin
      disp_d  = active_q[8*idx_q +: 8];
      anode_d = (ACTIVE_LOW != 0) ? ~onehot : onehot;
    end
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      idx_q     <= '0;
      phase_q   <= PH_BLANK;
      tcnt_q    <= '0;
      bright_q  <= '0;
      stage_q   <= BUF_OFF;
      active_q  <= BUF_OFF;
      pending_q <= 1'b0;
      disp_q    <= SEG_OFF;
      anode_q   <= AN_OFF;
      ft_q      <= 1'b0;
    end else begin
      idx_q     <= idx_d;
      phase_q   <= phase_d;
      tcnt_q    <= tcnt_d;
      bright_q  <= bright_d;
      stage_q   <= stage_d;
      active_q  <= active_d;
      pending_q <= pending_d;
      disp_q    <= disp_d;
      anode_q   <= anode_d;
      ft_q      <= boundary;
    end
  end

  assign disp       = disp_q;
  assign anode      = anode_q;
  assign frame_tick = ft_q;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Self-checking bench for seg_scan_ctrl with a timeline-based reference model.
module tb_seg_scan_ctrl;

  localparam int ND   = 4;
  localparam int TD   = 4;
  localparam int BW   = 2;
  localparam int BT   = 1;
  localparam int ONT  = 4;
  localparam int SL   = BT + ONT;
  localparam int FR   = ND * SL * TD;
  localparam int HMAX = 4096;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] seg_in = 32'hFFFF_FFFF;
  logic        load = 1'b0;
  logic [3:0]  digit_en = 4'h0;
  logic [1:0]  brightness = 2'd0;
  logic [7:0]  disp;
  logic [3:0]  anode;
  logic        frame_tick;

  seg_scan_ctrl #(
    .NUM_DIGITS(ND), .TICK_DIV(TD), .BRIGHT_W(BW), .BLANK_TICKS(BT), .ACTIVE_LOW(1)
  ) dut (
    .clk(clk), .rst(rst), .seg_in(seg_in), .load(load), .digit_en(digit_en),
    .brightness(brightness), .disp(disp), .anode(anode), .frame_tick(frame_tick)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int n = 0;

  logic [31:0] seg_h  [HMAX];
  logic        load_h [HMAX];
  logic [3:0]  en_h   [HMAX];
  logic [1:0]  br_h   [HMAX];

  logic [7:0] ed;
  logic [3:0] ea;
  logic       ef;

  // Record inputs of cycle n, advance one clock, sample at the negedge.
  task automatic cyc();
    if (n >= HMAX - 1) begin
      $display("FAIL history_overflow n=%0d limit=%0d", n, HMAX - 1);
      $fatal(1, "history overflow");
    end
    seg_h[n] = seg_in; load_h[n] = load; en_h[n] = digit_en; br_h[n] = brightness;
    @(posedge clk);
    @(negedge clk);
    n++;
  endtask

  // Active data after nn edges: last load at least two cycles before the latest frame boundary.
  function automatic logic [31:0] model_active(input int nn);
    int b;
    b = (nn / FR) * FR;
    for (int m = b - 2; m >= 0; m--)
      if (load_h[m]) return seg_h[m];
    return 32'hFFFF_FFFF;
  endfunction

  // Expected pins after nn edges since reset release.
  function automatic void model_out(input int nn, output logic [7:0] d,
                                    output logic [3:0] a, output logic f);
    int p, t, s, slot, idx, k, e;
    logic [31:0] act;
    f = (nn > 0) && (nn % FR == 0);
    d = 8'hFF;
    a = 4'hF;
    if (nn >= 1) begin
      p = nn - 1; t = p / TD; s = t % SL; slot = t / SL; idx = slot % ND;
      if (s >= BT) begin
        k = s - BT;
        e = (slot * SL + BT) * TD;
        if (en_h[p][idx] && k < int'(br_h[e-1])) begin
          act = model_active(p);
          a = ~(4'b0001 << idx);
          d = act[8*idx +: 8];
        end
      end
    end
  endfunction

  task automatic test_reset();
    rst = 1'b1; load = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0; n = 0;
    tests++;
    if (disp !== 8'hFF || anode !== 4'hF || frame_tick !== 1'b0) begin
      fails++;
      $display("FAIL reset got disp=%h anode=%b ft=%b exp disp=ff anode=1111 ft=0",
               disp, anode, frame_tick);
    end
  endtask

  task automatic test_basic();
    logic [7:0] dat [4];
    int cnt [4];
    int fts;
    dat[0] = 8'hB0; dat[1] = 8'hA4; dat[2] = 8'hF9; dat[3] = 8'hC0;
    for (int i = 0; i < 4; i++) cnt[i] = 0;
    fts = 0;
    digit_en = 4'hF; brightness = 2'd3; seg_in = 32'hC0F9A4B0; load = 1'b1;
    while (n < 2 * FR) begin
      cyc();
      load = 1'b0;
      model_out(n, ed, ea, ef);
      tests++;
      if (disp !== ed || anode !== ea || frame_tick !== ef) begin
        fails++;
        $display("FAIL basic n=%0d got disp=%h anode=%b ft=%b exp disp=%h anode=%b ft=%b",
                 n, disp, anode, frame_tick, ed, ea, ef);
      end
      if (frame_tick === 1'b1) fts++;
      if (n > FR)
        for (int i = 0; i < 4; i++)
          if (anode === ~(4'b0001 << i) && disp === dat[i]) cnt[i]++;
    end
    for (int i = 0; i < 4; i++) begin
      tests++;
      if (cnt[i] != 12) begin
        fails++;
        $display("FAIL basic_duty digit=%0d got %0d cycles exp 12", i, cnt[i]);
      end
    end
    tests++;
    if (fts != 2) begin
      fails++;
      $display("FAIL basic_frame_ticks got %0d exp 2", fts);
    end
  endtask

  task automatic test_brightness();
    int start, on1, on0, ndark;
    start = ((n + FR - 1) / FR) * FR;
    on1 = 0; on0 = 0; ndark = 0;
    digit_en = 4'hF;
    while (n < start + 2 * FR) begin
      if (n == start) brightness = 2'd1;
      if (n == start + FR) brightness = 2'd0;
      cyc();
      model_out(n, ed, ea, ef);
      tests++;
      if (disp !== ed || anode !== ea || frame_tick !== ef) begin
        fails++;
        $display("FAIL brightness n=%0d got disp=%h anode=%b ft=%b exp disp=%h anode=%b ft=%b",
                 n, disp, anode, frame_tick, ed, ea, ef);
      end
      if (n > start && n <= start + FR && anode !== 4'hF) on1++;
      if (n > start + FR && anode !== 4'hF) on0++;
      if (n > start + FR && disp !== 8'hFF) ndark++;
    end
    tests++;
    if (on1 != 16) begin
      fails++;
      $display("FAIL bright1_cycles got %0d exp 16", on1);
    end
    tests++;
    if (on0 != 0 || ndark != 0) begin
      fails++;
      $display("FAIL bright0_dark got anode_on=%0d disp_on=%0d exp 0 0", on0, ndark);
    end
  endtask

  task automatic test_digit_en();
    int n0, bad, good, last_ft, gaps;
    n0 = n; bad = 0; good = 0; last_ft = -1; gaps = 0;
    digit_en = 4'b0101; brightness = 2'd3;
    while (n < n0 + 2 * FR + 1) begin
      cyc();
      model_out(n, ed, ea, ef);
      tests++;
      if (disp !== ed || anode !== ea || frame_tick !== ef) begin
        fails++;
        $display("FAIL digit_en n=%0d got disp=%h anode=%b ft=%b exp disp=%h anode=%b ft=%b",
                 n, disp, anode, frame_tick, ed, ea, ef);
      end
      if (n > n0 + 1 && (anode === 4'b1101 || anode === 4'b0111)) bad++;
      if (anode === 4'b1110 || anode === 4'b1011) good++;
      if (frame_tick === 1'b1) begin
        if (last_ft >= 0) begin
          gaps++;
          tests++;
          if (n - last_ft != FR) begin
            fails++;
            $display("FAIL frame_period got %0d exp %0d", n - last_ft, FR);
          end
        end
        last_ft = n;
      end
    end
    tests++;
    if (bad != 0 || good == 0 || gaps == 0) begin
      fails++;
      $display("FAIL digit_en_pattern got disabled=%0d enabled=%0d gaps=%0d exp 0 >0 >0",
               bad, good, gaps);
    end
  endtask

  task automatic test_load();
    logic [31:0] d0, d1, d2;
    int n0, b1;
    d0 = 32'h92_99_82_F8; d1 = 32'h80_90_88_83; d2 = 32'hC6_A1_86_8E;
    digit_en = 4'hF; brightness = 2'd3;
    n0 = n;
    b1 = ((n0 + 2 + FR - 1) / FR) * FR;
    while (n < b1 + 3 * FR + 8) begin
      load = 1'b0;
      if (n == n0)             begin seg_in = d0; load = 1'b1; end
      if (n == b1 + 40)        begin seg_in = d1; load = 1'b1; end
      if (n == b1 + 2*FR - 1)  begin seg_in = d2; load = 1'b1; end
      cyc();
      load = 1'b0;
      model_out(n, ed, ea, ef);
      tests++;
      if (disp !== ed || anode !== ea || frame_tick !== ef) begin
        fails++;
        $display("FAIL load n=%0d got disp=%h anode=%b ft=%b exp disp=%h anode=%b ft=%b",
                 n, disp, anode, frame_tick, ed, ea, ef);
      end
      if (n == b1 + 65) begin
        tests++;
        if (disp !== d0[31:24] || anode !== 4'b0111) begin
          fails++;
          $display("FAIL load_old_kept got disp=%h anode=%b exp disp=%h anode=0111",
                   disp, anode, d0[31:24]);
        end
      end
      if (n == b1 + FR + 5 || n == b1 + 2*FR + 5) begin
        tests++;
        if (disp !== d1[7:0] || anode !== 4'b1110) begin
          fails++;
          $display("FAIL load_new_applied n=%0d got disp=%h anode=%b exp disp=%h anode=1110",
                   n, disp, anode, d1[7:0]);
        end
      end
      if (n == b1 + 3*FR + 5) begin
        tests++;
        if (disp !== d2[7:0] || anode !== 4'b1110) begin
          fails++;
          $display("FAIL load_coincident got disp=%h anode=%b exp disp=%h anode=1110",
                   disp, anode, d2[7:0]);
        end
      end
    end
  endtask

  task automatic test_bright_change();
    int b, c0, c1;
    digit_en = 4'hF; brightness = 2'd3;
    b = ((n + FR - 1) / FR) * FR;
    c0 = 0; c1 = 0;
    while (n < b + 40) begin
      if (n == b + 10) brightness = 2'd1;
      cyc();
      model_out(n, ed, ea, ef);
      tests++;
      if (disp !== ed || anode !== ea || frame_tick !== ef) begin
        fails++;
        $display("FAIL bright_change n=%0d got disp=%h anode=%b ft=%b exp disp=%h anode=%b ft=%b",
                 n, disp, anode, frame_tick, ed, ea, ef);
      end
      if (n > b && n <= b + 20 && anode !== 4'hF) c0++;
      if (n > b + 20 && n <= b + 40 && anode !== 4'hF) c1++;
    end
    tests++;
    if (c0 != 12 || c1 != 4) begin
      fails++;
      $display("FAIL bright_change_duty got %0d/%0d exp 12/4", c0, c1);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 800; i++) begin
      seg_in = $urandom;
      load = ($urandom_range(0, 19) == 0);
      brightness = 2'($urandom_range(0, 3));
      if (i % 50 == 0) digit_en = 4'($urandom_range(0, 15));
      cyc();
      load = 1'b0;
      model_out(n, ed, ea, ef);
      tests++;
      if (disp !== ed || anode !== ea || frame_tick !== ef) begin
        fails++;
        $display("FAIL random n=%0d got disp=%h anode=%b ft=%b exp disp=%h anode=%b ft=%b",
                 n, disp, anode, frame_tick, ed, ea, ef);
      end
    end
  endtask

  task automatic test_rst_mid();
    logic [31:0] d;
    d = 32'hA1_B2_C3_D4;
    digit_en = 4'hF; brightness = 2'd3;
    seg_in = 32'h11223344; load = 1'b1;
    cyc();
    load = 1'b0;
    while (n % FR != 50) cyc();
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    tests++;
    if (disp !== 8'hFF || anode !== 4'hF || frame_tick !== 1'b0) begin
      fails++;
      $display("FAIL rst_mid got disp=%h anode=%b ft=%b exp disp=ff anode=1111 ft=0",
               disp, anode, frame_tick);
    end
    rst = 1'b0; n = 0;
    while (n < 2 * FR + 10) begin
      load = 1'b0;
      if (n == 10) begin seg_in = d; load = 1'b1; end
      cyc();
      load = 1'b0;
      model_out(n, ed, ea, ef);
      tests++;
      if (disp !== ed || anode !== ea || frame_tick !== ef) begin
        fails++;
        $display("FAIL rst_restart n=%0d got disp=%h anode=%b ft=%b exp disp=%h anode=%b ft=%b",
                 n, disp, anode, frame_tick, ed, ea, ef);
      end
      if (n == BT * TD + 1) begin
        tests++;
        if (anode !== 4'b1110 || disp !== 8'hFF) begin
          fails++;
          $display("FAIL rst_first_digit got anode=%b disp=%h exp anode=1110 disp=ff", anode, disp);
        end
      end
      if (n == FR + BT * TD + 1) begin
        tests++;
        if (anode !== 4'b1110 || disp !== d[7:0]) begin
          fails++;
          $display("FAIL rst_reload got anode=%b disp=%h exp anode=1110 disp=%h",
                   anode, disp, d[7:0]);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_brightness();
    test_digit_en();
    test_load();
    test_bright_change();
    test_random();
    test_rst_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
